// File: rtl/rel_fifo_stream_out_pkg.sv
// -----------------------------------------------------------------------------
// rel_fifo_stream_out_pkg
// Shared constants and helpers for the rel_fifo output stage.
//  NumReplicas : number of redundant control replicas (triple modular redundancy)
//  maj3()      : 2-of-3 majority of a 3-bit vector, used by simulation checks
// -----------------------------------------------------------------------------
package rel_fifo_stream_out_pkg;

    localparam int unsigned NumReplicas = 3;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/TMR_voter_fail.sv
// -----------------------------------------------------------------------------
// TMR_voter_fail
// 1-bit 2-of-3 majority voter with disagreement flag.
//  a_i, b_i, c_i     in   1  replica values
//  majority_o        out  1  voted value
//  fault_detected_o  out  1  high when the replicas do not all agree
// -----------------------------------------------------------------------------
module TMR_voter_fail (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic majority_o,
    output logic fault_detected_o
);

    assign majority_o       = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    assign fault_detected_o = (a_i ^ b_i) | (a_i ^ c_i);

endmodule

// File: rtl/bitwise_TMR_voter_fail.sv
// -----------------------------------------------------------------------------
// bitwise_TMR_voter_fail
// Per-bit 2-of-3 majority voter over a vector with a single disagreement flag.
//  a_i, b_i, c_i     in   DataWidth  replica vectors
//  majority_o        out  DataWidth  per-bit voted vector
//  fault_detected_o  out  1          high when any bit position disagrees
// -----------------------------------------------------------------------------
module bitwise_TMR_voter_fail #(
    parameter int unsigned DataWidth = 32
) (
    input  logic [DataWidth-1:0] a_i,
    input  logic [DataWidth-1:0] b_i,
    input  logic [DataWidth-1:0] c_i,
    output logic [DataWidth-1:0] majority_o,
    output logic                 fault_detected_o
);

    assign majority_o       = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    assign fault_detected_o = |((a_i ^ b_i) | (a_i ^ c_i));

endmodule

// File: rtl/rel_fifo_stream_out_tmr_part.sv
// -----------------------------------------------------------------------------
// rel_fifo_stream_out_tmr_part
// One control replica of the rel_fifo output stage: the occupied flag, its
// majority voter (own flop plus the two other replicas) and the pop / next-state
// logic. Next state is computed from the voted flag only, so a flipped flop is
// realigned with its siblings after one clock.
//  clk_i, rst_ni    in   1  clock, asynchronous active-low reset
//  flush_i          in   1  drop register contents
//  empty_i          in   1  FIFO empty
//  ready_i          in   1  sink ready
//  occ_alt_a_i/b_i  in   1  occupied flags of the two other replicas
//  occ_o            out  1  this replica's raw occupied flop
//  occ_v_o          out  1  voted occupied flag (valid)
//  pop_o            out  1  pop request of this replica
//  fault_o          out  1  occupied-flag vote disagreement
// -----------------------------------------------------------------------------
module rel_fifo_stream_out_tmr_part (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic empty_i,
    input  logic ready_i,
    input  logic occ_alt_a_i,
    input  logic occ_alt_b_i,
    output logic occ_o,
    output logic occ_v_o,
    output logic pop_o,
    output logic fault_o
);

    logic occ_q;
    logic occ_d;
    logic occ_v;
    logic pop;

    TMR_voter_fail i_occ_voter (
        .a_i              (occ_q),
        .b_i              (occ_alt_a_i),
        .c_i              (occ_alt_b_i),
        .majority_o       (occ_v),
        .fault_detected_o (fault_o)
    );

    always_comb begin
        pop   = ~flush_i & ~empty_i & (~occ_v | ready_i);
        occ_d = 1'b0;
        if (!flush_i) begin
            // Reload on pop, otherwise hold while the sink stalls.
            occ_d = pop | (occ_v & ~ready_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ_o   = occ_q;
    assign occ_v_o = occ_v;
    assign pop_o   = pop;

endmodule

// File: rtl/rel_fifo_stream_out.sv
// -----------------------------------------------------------------------------
// rel_fifo_stream_out
// Output stage of rel_fifo: pops the FIFO head into a one-entry register and
// presents it as a valid/ready stream. Control is triplicated with cross-voting;
// data (ECC bits included) passes through undecoded.
//  DataWidth  width of the data path
//  TmrStatus  1: handshake/status ports are 3-bit (one bit per replica)
//             0: 1-bit ports, broadcast in, voted out
//  clk_i         in   1          clock
//  rst_ni        in   1          asynchronous reset, active-low
//  flush_i       in   HsWidth    drop register contents
//  fifo_empty_i  in   HsWidth    FIFO empty
//  fifo_data_i   in   DataWidth  FIFO head data
//  fifo_pop_o    out  HsWidth    FIFO pop
//  valid_o       out  HsWidth    register holds data
//  ready_i       in   HsWidth    sink accepts data_o
//  data_o        out  DataWidth  registered head data
//  fault_o       out  1          any voter disagreement (combinational)
// -----------------------------------------------------------------------------
module rel_fifo_stream_out
    import rel_fifo_stream_out_pkg::*;
#(
    parameter int unsigned  DataWidth = 39,
    parameter bit           TmrStatus = 1'b0,
    localparam int unsigned HsWidth   = TmrStatus ? 3 : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [HsWidth-1:0]   flush_i,
    input  logic [HsWidth-1:0]   fifo_empty_i,
    input  logic [DataWidth-1:0] fifo_data_i,
    output logic [HsWidth-1:0]   fifo_pop_o,
    output logic [HsWidth-1:0]   valid_o,
    input  logic [HsWidth-1:0]   ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 fault_o
);

    logic [NumReplicas-1:0] flush_r;
    logic [NumReplicas-1:0] empty_r;
    logic [NumReplicas-1:0] ready_r;
    logic [NumReplicas-1:0] occ_q_r;
    logic [NumReplicas-1:0] occ_v_r;
    logic [NumReplicas-1:0] pop_r;
    logic [NumReplicas-1:0] occ_fault_r;

    logic [DataWidth-1:0]   load_en;
    logic                   en_fault;
    logic                   out_fault;
    logic [DataWidth-1:0]   data_q;

    // Replicas
    for (genvar gi = 0; gi < NumReplicas; gi++) begin : gen_replica
        if (TmrStatus) begin : gen_tmr_in
            assign flush_r[gi] = flush_i[gi];
            assign empty_r[gi] = fifo_empty_i[gi];
            assign ready_r[gi] = ready_i[gi];
        end else begin : gen_bcast_in
            assign flush_r[gi] = flush_i[0];
            assign empty_r[gi] = fifo_empty_i[0];
            assign ready_r[gi] = ready_i[0];
        end

        (* no_ungroup *) (* no_boundary_optimization *)
        rel_fifo_stream_out_tmr_part i_part (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .flush_i     (flush_r[gi]),
            .empty_i     (empty_r[gi]),
            .ready_i     (ready_r[gi]),
            .occ_alt_a_i (occ_q_r[(gi + 1) % NumReplicas]),
            .occ_alt_b_i (occ_q_r[(gi + 2) % NumReplicas]),
            .occ_o       (occ_q_r[gi]),
            .occ_v_o     (occ_v_r[gi]),
            .pop_o       (pop_r[gi]),
            .fault_o     (occ_fault_r[gi])
        );
    end

    // Each data bit gets its own voted load enable so a single upset in the
    // enable fan-out cannot corrupt more than the replica it hits.
    bitwise_TMR_voter_fail #(
        .DataWidth (DataWidth)
    ) i_en_voter (
        .a_i              ({DataWidth{pop_r[0]}}),
        .b_i              ({DataWidth{pop_r[1]}}),
        .c_i              ({DataWidth{pop_r[2]}}),
        .majority_o       (load_en),
        .fault_detected_o (en_fault)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            for (int i = 0; i < int'(DataWidth); i++) begin
                if (load_en[i]) begin
                    data_q[i] <= fifo_data_i[i];
                end
            end
        end
    end

    assign data_o = data_q;

    // Output / status
    if (TmrStatus) begin : gen_tmr_out
        assign fifo_pop_o = pop_r;
        assign valid_o    = occ_v_r;
        assign out_fault  = 1'b0;
    end else begin : gen_voted_out
        logic pop_fault;
        logic valid_fault;

        TMR_voter_fail i_pop_voter (
            .a_i              (pop_r[0]),
            .b_i              (pop_r[1]),
            .c_i              (pop_r[2]),
            .majority_o       (fifo_pop_o[0]),
            .fault_detected_o (pop_fault)
        );

        TMR_voter_fail i_valid_voter (
            .a_i              (occ_v_r[0]),
            .b_i              (occ_v_r[1]),
            .c_i              (occ_v_r[2]),
            .majority_o       (valid_o[0]),
            .fault_detected_o (valid_fault)
        );

        assign out_fault = pop_fault | valid_fault;
    end

    assign fault_o = (|occ_fault_r) | en_fault | out_fault;

`ifndef RED_CELLS_ASSERTS_OFF
    logic valid_vote;
    logic ready_vote;

    assign valid_vote = maj3(occ_v_r);
    assign ready_vote = maj3(ready_r);

    a_no_pop_when_empty : assert property (
        @(posedge clk_i) disable iff (!rst_ni) ((pop_r & empty_r) == '0)
    );

    a_stall_data_stable : assert property (
        @(posedge clk_i) disable iff (!rst_ni) (valid_vote & ~ready_vote) |=> $stable(data_o)
    );
`endif

endmodule

// File: tb/tb_rel_fifo_stream_out.sv
// -----------------------------------------------------------------------------
// tb_rel_fifo_stream_out
// Drives two instances (broadcast 1-bit status and triplicated 3-bit status)
// from a behavioural FIFO. Words written into the FIFO are queued as the
// expected stream; a monitor pops that queue on every valid/ready handshake.
// A per-cycle reference of the occupied flag, pop and held data is kept, and
// the triplicated instance gets single-replica input upsets to exercise masking
// and fault reporting.
// -----------------------------------------------------------------------------
module tb_rel_fifo_stream_out;

    localparam int unsigned DW = 39;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    // Stimulus state
    logic          flush_s = 1'b0;
    logic          ready_s = 1'b1;
    logic          empty_s = 1'b1;
    logic          push_s  = 1'b0;
    logic [DW-1:0] head_s  = '0;
    logic [2:0]    rdy_m   = '0;
    logic [2:0]    emp_m   = '0;

    // DUT0: TmrStatus = 0
    logic          d0_pop, d0_valid, d0_fault;
    logic [DW-1:0] d0_data;
    // DUT1: TmrStatus = 1
    logic [2:0]    d1_flush, d1_empty, d1_ready, d1_pop, d1_valid;
    logic          d1_fault;
    logic [DW-1:0] d1_data;

    assign d1_flush = {3{flush_s}};
    assign d1_empty = {3{empty_s}} ^ emp_m;
    assign d1_ready = {3{ready_s}} ^ rdy_m;

    rel_fifo_stream_out #(.DataWidth(DW), .TmrStatus(1'b0)) dut0 (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_s),
        .fifo_empty_i (empty_s),
        .fifo_data_i  (head_s),
        .fifo_pop_o   (d0_pop),
        .valid_o      (d0_valid),
        .ready_i      (ready_s),
        .data_o       (d0_data),
        .fault_o      (d0_fault)
    );

    rel_fifo_stream_out #(.DataWidth(DW), .TmrStatus(1'b1)) dut1 (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (d1_flush),
        .fifo_empty_i (d1_empty),
        .fifo_data_i  (head_s),
        .fifo_pop_o   (d1_pop),
        .valid_o      (d1_valid),
        .ready_i      (d1_ready),
        .data_o       (d1_data),
        .fault_o      (d1_fault)
    );

    // Reference model
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic          occ_ref  = 1'b0;
    logic [DW-1:0] data_ref = '0;
    logic [2:0]    occr_q   = '0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[DW-1:0];
    endfunction

    function automatic logic pop_of(input logic e, input logic r);
        return ~flush_s & ~e & (~occ_ref | r);
    endfunction

    task automatic model_reset();
        occ_ref  = 1'b0;
        data_ref = '0;
        occr_q   = '0;
        fifo_q.delete();
        exp_q.delete();
    endtask

    // Applied at the clock edge, with the inputs of the cycle just ending.
    task automatic model_update();
        logic          p0;
        logic [2:0]    occr_next;
        logic [DW-1:0] w;
        p0 = pop_of(empty_s, ready_s);
        for (int r = 0; r < 3; r++) begin
            occr_next[r] = flush_s ? 1'b0
                         : (pop_of(d1_empty[r], d1_ready[r]) | (occ_ref & ~d1_ready[r]));
        end
        if (p0) data_ref = fifo_q.pop_front();
        occ_ref = flush_s ? 1'b0 : (p0 | (occ_ref & ~ready_s));
        occr_q  = occr_next;
        if (flush_s) begin
            fifo_q.delete();
            exp_q.delete();
        end
        if (push_s) begin
            w = rand_word();
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    // corrupt: 1 = flip one replica's ready, 2 = flip one replica's empty
    task automatic drive(input logic fl, input logic rd, input logic ps, input int corrupt);
        int idx;
        flush_s = fl;
        ready_s = rd;
        push_s  = ps;
        empty_s = (fifo_q.size() == 0);
        head_s  = empty_s ? rand_word() : fifo_q[0];
        rdy_m   = '0;
        emp_m   = '0;
        idx     = $urandom_range(2, 0);
        if (corrupt == 1) rdy_m[idx] = 1'b1;
        if (corrupt == 2) emp_m[idx] = 1'b1;
    endtask

    task automatic step(input logic fl, input logic rd, input logic ps, input int corrupt);
        @(posedge clk_i);
        if (rst_ni) model_update();
        #1;
        drive(fl, rd, ps, corrupt);
    endtask

    // Per-cycle checks and stream scoreboard
    initial begin
        logic [2:0] p1;
        logic       f1;
        forever begin
            @(negedge clk_i);
            for (int r = 0; r < 3; r++) p1[r] = pop_of(d1_empty[r], d1_ready[r]);
            f1 = ((p1 != 3'b000) && (p1 != 3'b111)) || ((occr_q != 3'b000) && (occr_q != 3'b111));
            chk("d0_valid", d0_valid, occ_ref);
            chk("d0_pop",   d0_pop,   pop_of(empty_s, ready_s));
            chk("d0_data",  d0_data,  data_ref);
            chk("d0_fault", d0_fault, 1'b0);
            chk("d1_valid", d1_valid, {3{occ_ref}});
            chk("d1_pop",   d1_pop,   p1);
            chk("d1_data",  d1_data,  data_ref);
            chk("d1_fault", d1_fault, f1);
            if (rst_ni && d0_valid && ready_s && !flush_s) begin
                if (exp_q.size() == 0) begin
                    chk("stream_underflow", 1'b1, 1'b0);
                end else begin
                    chk("stream_data", d0_data, exp_q.pop_front());
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic fl, rd, ps;
        int   cr;
        model_reset();
        drive(1'b0, 1'b1, 1'b0, 0);
        // Idle in reset with empty=1, ready=1.
        repeat (5) step(1'b0, 1'b1, 1'b0, 0);

        // Three words already in the FIFO, sink always ready.
        fifo_q.push_back(39'h11); exp_q.push_back(39'h11);
        fifo_q.push_back(39'h22); exp_q.push_back(39'h22);
        fifo_q.push_back(39'h33); exp_q.push_back(39'h33);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 0);
        repeat (6) step(1'b0, 1'b1, 1'b0, 0);

        // Load one word, then stall the sink with more data waiting.
        step(1'b0, 1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 1'b1, 0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 0);
        repeat (4) step(1'b0, 1'b1, 1'b0, 0);

        // Three-replica-ready pattern 101 while occupied and non-empty.
        step(1'b0, 1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 1'b1, 0);
        @(posedge clk_i);
        model_update();
        #1;
        drive(1'b0, 1'b1, 1'b0, 0);
        rdy_m = 3'b010;
        repeat (3) step(1'b0, 1'b1, 1'b0, 0);

        // Flush while occupied and non-empty.
        step(1'b0, 1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 1'b1, 0);
        step(1'b1, 1'b0, 1'b0, 0);
        repeat (2) step(1'b0, 1'b1, 1'b0, 0);

        // Randomised traffic with a mid-stream asynchronous reset.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                step(1'b0, 1'b0, 1'b1, 0);
                #2;
                rst_ni = 1'b0;
                model_reset();
                drive(1'b0, 1'b1, 1'b0, 0);
                #1;
                chk("rst_d0_valid", d0_valid, 1'b0);
                chk("rst_d0_pop",   d0_pop,   1'b0);
                chk("rst_d0_data",  d0_data,  '0);
                chk("rst_d0_fault", d0_fault, 1'b0);
                chk("rst_d1_valid", d1_valid, 3'b000);
                chk("rst_d1_data",  d1_data,  '0);
                repeat (2) step(1'b0, 1'b1, 1'b0, 0);
                @(posedge clk_i);
                #1;
                rst_ni = 1'b1;
                drive(1'b0, 1'b1, 1'b0, 0);
            end
            fl = ($urandom_range(99, 0) < 4);
            rd = fl ? 1'b0 : ($urandom_range(99, 0) < 65);
            ps = !fl && ($urandom_range(99, 0) < 55);
            cr = $urandom_range(4, 0);
            step(fl, rd, ps, cr);
        end
        repeat (2) step(1'b0, 1'b1, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
